// File: rtl/rocc_accel_responder.sv
// rocc_accel_responder: RoCC command/response endpoint with accumulator bank and shift-add multiplier.
// Optional cycle/command counters for opcode 5 when ROCC_ACCEL_PERF_CNT_EN is defined.
`default_nettype none

module rocc_accel_responder #(
  parameter int NUM_ACC  = 4,
  parameter int MUL_STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [63:0] cmd_rs1_i,
  input  logic [63:0] cmd_rs2_i,
  input  logic [6:0]  cmd_instr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_data_o,
  output logic        busy_o
);

  localparam int IDX_W            = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int MUL_CYCLES       = 64 / MUL_STEP;
  localparam logic [6:0] MUL_LAST = 7'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_WRITE  = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_ACCUM  = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_CYCLES = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             accept, mul_last;
  logic [2:0]       op;
  logic [IDX_W-1:0] idx_in, idx_q;
  logic [63:0]      acc [NUM_ACC];
  logic [63:0]      acc_sel, accum_sum;
  logic [63:0]      mcand, mplier, prod, prod_next, partial;
  logic [6:0]       mul_cnt;
  logic [63:0]      resp_data;
  logic [63:0]      perf_val;
  logic             unused_instr;

  assign op           = cmd_instr_i[2:0];
  assign idx_in       = cmd_rs2_i[IDX_W-1:0];
  assign acc_sel      = acc[idx_in];
  assign accum_sum    = acc_sel + cmd_rs1_i;
  assign accept       = cmd_valid_i && cmd_ready_o;
  assign mul_last     = (mul_cnt == MUL_LAST);
  assign resp_data_o  = resp_data;
  assign unused_instr = ^cmd_instr_i[6:3];

`ifdef ROCC_ACCEL_PERF_CNT_EN
  logic [63:0] cyc_cnt, cmd_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt <= '0;
      cmd_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (accept) cmd_cnt <= cmd_cnt + 64'd1;
    end
  end

  // Command count reported for the current command includes itself.
  assign perf_val = cmd_rs1_i[0] ? (cmd_cnt + 64'd1) : cyc_cnt;
`else
  assign perf_val = '1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cmd_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) state_next = (op == OP_MUL) ? MUL : RESP;
      end
      MUL: begin
        if (mul_last) state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One shift-add step retiring MUL_STEP multiplier bits.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
    prod_next = prod + partial;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      resp_data <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      mul_cnt   <= '0;
      idx_q     <= '0;
    end else if (accept) begin
      idx_q   <= idx_in;
      mcand   <= cmd_rs1_i;
      mplier  <= cmd_rs2_i;
      prod    <= '0;
      mul_cnt <= '0;
      case (op)
        OP_WRITE: begin
          acc[idx_in] <= cmd_rs1_i;
          resp_data   <= acc_sel;
        end
        OP_READ:  resp_data <= acc_sel;
        OP_ACCUM: begin
          acc[idx_in] <= accum_sum;
          resp_data   <= accum_sum;
        end
        OP_MUL: ;
        OP_CLEAR: begin
          for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
          resp_data <= '0;
        end
        OP_CYCLES: resp_data <= perf_val;
        default:   resp_data <= '1;
      endcase
    end else if (state == MUL) begin
      prod    <= prod_next;
      mcand   <= mcand << MUL_STEP;
      mplier  <= mplier >> MUL_STEP;
      mul_cnt <= mul_cnt + 7'd1;
      if (mul_last) begin
        acc[idx_q] <= prod_next;
        resp_data  <= prod_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/rocc_accel_responder.md
Name: rocc_accel_responder

Overview:
Accelerator-side endpoint of the core's RoCC command/response interface. Accepts one command at a time (rs1, rs2, 7-bit instr) over a valid/ready handshake, executes it against a small bank of 64-bit accumulator registers or an iterative multiplier, and returns exactly one 64-bit response per command, in order. Sits outside the issue pipeline; the core side tracks transaction IDs, so the responder carries none.

Parameters:
NUM_ACC, 4, number of 64-bit accumulator registers; power of 2, 2..16.
MUL_STEP, 1, multiplier bits retired per cycle; one of 1, 2, 4, 8.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  responder can accept a command
cmd_rs1_i  input  64  operand rs1
cmd_rs2_i  input  64  operand rs2; bits [log2(NUM_ACC)-1:0] select the accumulator
cmd_instr_i  input  7  opcode; bits [2:0] used, bits [6:3] ignored
resp_valid_o  output  1  response valid
resp_ready_i  input  1  core accepts response
resp_data_o  output  64  response data
busy_o  output  1  command accepted but response not yet consumed

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset state: IDLE. All accumulators are 0. resp_valid_o=0, resp_data_o=0, busy_o=0. cmd_ready_o=1 once reset is deasserted.
- FSM states: IDLE, MUL, RESP.
- In IDLE, cmd_ready_o=1. All other states drive cmd_ready_o=0.
- A command is accepted when cmd_valid_i && cmd_ready_o. Accepted rs1, rs2 and instr are captured into registers.
- Opcodes (instr[2:0]). The response is registered and resp_valid_o rises the cycle after acceptance unless noted.
  - 0 WRITE: acc[idx] <= rs1; response = previous acc[idx].
  - 1 READ: response = acc[idx].
  - 2 ACCUM: acc[idx] <= acc[idx] + rs1, mod 2^64; response = the new value.
  - 3 MUL: go to MUL. Shift-add rs1*rs2 at MUL_STEP multiplier bits per cycle, 64/MUL_STEP cycles. Then acc[idx] <= low 64 bits of the product, response = the same value, go to RESP. resp_valid_o rises 64/MUL_STEP+1 cycles after acceptance.
  - 4 CLEAR: all accumulators <= 0; response = 0.
  - 5 CYCLES: see Optional Feature.
  - 6, 7: no state change; response = all ones (0xFFFF_FFFF_FFFF_FFFF).
- RESP: resp_valid_o=1 and resp_data_o is held stable until resp_valid_o && resp_ready_i. On that handshake cycle go to IDLE, so cmd_ready_o=1 on the next cycle.
- Throughput: at most one command per two cycles; no overlap of a pending response with a new acceptance.
- Backpressure: resp_ready_i may be low arbitrarily long. Data stays stable, and cmd_valid_i is ignored while not in IDLE.
- busy_o=1 from the cycle after acceptance until the cycle after the response handshake, i.e. whenever the state is not IDLE.
- Index bits above log2(NUM_ACC) in rs2 are ignored. For MUL, the full rs2 is the multiplier; idx is still rs2[log2(NUM_ACC)-1:0].
- Reset asserted mid-MUL or mid-RESP: the FSM returns to IDLE and accumulators clear. No response is emitted for the in-flight command.
- No flush input. The core must not abandon a command, because every accepted command yields exactly one response.

Optional Feature:
Macro ROCC_ACCEL_PERF_CNT_EN.
- Defined: a 64-bit free-running cycle counter and a 64-bit accepted-command counter, both reset to 0 and wrapping at 2^64. Opcode 5 returns the cycle counter if rs1[0]=0, or the command counter if rs1[0]=1. The sampled value is taken in the acceptance cycle, and the command counter already includes the current command.
- Not defined: no counters are instantiated. Opcode 5 behaves like opcodes 6/7 (response all ones).

Test Plan:
- Reset, then WRITE rs1=0x1234, rs2=2 -> resp_valid_o=1 one cycle after acceptance, resp_data_o=0. A following READ with rs2=2 returns 0x1234.
- ACCUM on acc1 starting at 0xFFFF_FFFF_FFFF_FFFF with rs1=2 -> response 0x1, and acc1 reads back 0x1 (wrap).
- MUL rs1=7, rs2=0x3 (idx 3), MUL_STEP=1 -> cmd_ready_o=0 for 65 cycles, response 0x15, acc3=0x15. Repeat with MUL_STEP=4 -> response arrives 17 cycles after acceptance.
- Hold resp_ready_i=0 for 10 cycles after a READ while cmd_valid_i stays high with a new command -> resp_data_o is stable, no second acceptance, busy_o=1. When resp_ready_i rises: one handshake, then the new command is accepted the following cycle.
- Pulse rst_ni low during MUL -> resp_valid_o=0, busy_o=0, accumulators read 0, cmd_ready_o=1 after release.
- Opcode 7 -> response 0xFFFF_FFFF_FFFF_FFFF. With ROCC_ACCEL_PERF_CNT_EN defined, opcode 5 with rs1=1 sent as the third command -> response 3.
